// File: rtl/gpio_bank_sequencer.sv
// Shares a tri-state test bank between two requesters: drive a pattern, wait a
// settle time, sample the pins through a 2-flop synchronizer, then release to high-Z.
module gpio_bank_sequencer #(
  parameter int PINS   = 12,
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [PINS-1:0] dir0,
  input  logic [PINS-1:0] out0,
  input  logic [PINS-1:0] dir1,
  input  logic [PINS-1:0] out1,
  output logic [1:0]      grant,
  output logic [1:0]      done,
  output logic [PINS-1:0] rdata,
  output logic            busy,
  output logic [PINS-1:0] pins_dir,
  output logic [PINS-1:0] pins_out,
  input  logic [PINS-1:0] pins_in
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_RELEASE
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic            last, last_nxt;
  logic            win;
  logic [1:0]      grant_nxt, done_nxt;
  logic [PINS-1:0] rdata_nxt, dir_nxt, out_nxt;
  logic [PINS-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      grant    <= '0;
      done     <= '0;
      rdata    <= '0;
      pins_dir <= '0;
      pins_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      grant    <= grant_nxt;
      done     <= done_nxt;
      rdata    <= rdata_nxt;
      pins_dir <= dir_nxt;
      pins_out <= out_nxt;
      sync1    <= pins_in;
      sync2    <= sync1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    grant_nxt = grant;
    done_nxt  = done;
    rdata_nxt = rdata;
    dir_nxt   = pins_dir;
    out_nxt   = pins_out;
    win       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          // Contention alternates away from the last served client.
          win       = (req == 2'b11) ? ~last : req[1];
          grant_nxt = win ? 2'b10 : 2'b01;
          dir_nxt   = win ? dir1 : dir0;
          out_nxt   = win ? (out1 & dir1) : (out0 & dir0);
          last_nxt  = win;
          cnt_nxt   = 8'(SETTLE - 1);
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == 8'd0) state_nxt = S_SAMPLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      S_SAMPLE: begin
        rdata_nxt = sync2;
        done_nxt  = grant;
        state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        dir_nxt   = '0;
        out_nxt   = '0;
        grant_nxt = '0;
        done_nxt  = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_gpio_bank_sequencer.sv
// Directed bench for gpio_bank_sequencer: the pin bank is modelled as tri-state
// buffers with pull-downs plus an optional external driver on undriven pins.
module tb_gpio_bank_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [11:0] dir0, out0, dir1, out1;
  logic [1:0]  grant, done;
  logic [11:0] rdata;
  logic        busy;
  logic [11:0] pins_dir, pins_out, pins_in;
  logic [11:0] ext;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign pins_in = (pins_out & pins_dir) | (ext & ~pins_dir);

  gpio_bank_sequencer #(.PINS(12), .SETTLE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dir0     (dir0),
    .out0     (out0),
    .dir1     (dir1),
    .out1     (out1),
    .grant    (grant),
    .done     (done),
    .rdata    (rdata),
    .busy     (busy),
    .pins_dir (pins_dir),
    .pins_out (pins_out),
    .pins_in  (pins_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst  = 1'b1;
    req  = 2'b00;
    dir0 = 12'h003;
    out0 = 12'h001;
    dir1 = 12'h0F0;
    out1 = 12'hFFF;
    ext  = 12'h000;
    do_reset();

    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_pins_dir", 32'(pins_dir), 32'h0);
    chk("rst_pins_out", 32'(pins_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single request from client 0
    req = 2'b01;
    tick();
    chk("t1_c1_grant", 32'(grant), 32'h1);
    chk("t1_c1_dir", 32'(pins_dir), 32'h003);
    chk("t1_c1_out", 32'(pins_out), 32'h001);
    chk("t1_c1_busy", 32'(busy), 32'h1);
    dir0 = 12'hFFF;
    out0 = 12'hFFF;
    tick(); tick(); tick();
    chk("t1_c4_dir_held", 32'(pins_dir), 32'h003);
    chk("t1_c4_out_held", 32'(pins_out), 32'h001);
    tick();
    chk("t1_c5_done", 32'(done), 32'h0);
    tick();
    chk("t1_c6_done", 32'(done), 32'h1);
    chk("t1_c6_rdata", 32'(rdata), 32'h001);
    req = 2'b00;
    tick();
    chk("t1_c7_dir", 32'(pins_dir), 32'h0);
    chk("t1_c7_out", 32'(pins_out), 32'h0);
    chk("t1_c7_grant", 32'(grant), 32'h0);
    chk("t1_c7_done", 32'(done), 32'h0);
    chk("t1_c7_busy", 32'(busy), 32'h0);
    chk("t1_c7_rdata_held", 32'(rdata), 32'h001);
    dir0 = 12'h003;
    out0 = 12'h001;

    // Simultaneous requests after reset; client 1 also checks masking/readback
    do_reset();
    req = 2'b11;
    tick();
    chk("t2_c1_grant", 32'(grant), 32'h1);
    repeat (5) tick();
    chk("t2_c6_done", 32'(done), 32'h1);
    chk("t2_c6_rdata", 32'(rdata), 32'h001);
    req = 2'b10;
    tick();
    chk("t2_c7_grant", 32'(grant), 32'h0);
    chk("t2_c7_dir", 32'(pins_dir), 32'h0);
    ext = 12'h100;
    tick();
    chk("t2_c8_grant", 32'(grant), 32'h2);
    chk("t2_c8_dir", 32'(pins_dir), 32'h0F0);
    chk("t2_c8_out_masked", 32'(pins_out), 32'h0F0);
    repeat (4) tick();
    chk("t2_c12_done", 32'(done), 32'h0);
    tick();
    chk("t2_c13_done", 32'(done), 32'h2);
    chk("t2_c13_rdata", 32'(rdata), 32'h1F0);
    req = 2'b00;
    tick();
    ext = 12'h000;
    chk("t2_c14_busy", 32'(busy), 32'h0);

    // Sustained contention: strict alternation with a 7-cycle period
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t3_grant%0d", k), 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      repeat (4) tick();
      chk($sformatf("t3_nodone%0d", k), 32'(done), 32'h0);
      tick();
      chk($sformatf("t3_done%0d", k), 32'(done), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k == 3) req = 2'b00;
      tick();
      chk($sformatf("t3_idle%0d", k), 32'(busy), 32'h0);
    end
    tick();
    chk("t3_no_extra", 32'(busy), 32'h0);

    // Reset asserted in cycle 2 of SETTLE
    req = 2'b01;
    tick();
    tick();
    chk("t4_c2_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("t4_rst_dir", 32'(pins_dir), 32'h0);
    chk("t4_rst_grant", 32'(grant), 32'h0);
    chk("t4_rst_busy", 32'(busy), 32'h0);
    req = 2'b00;
    tick();
    chk("t4_rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    tick();
    chk("t4_post_done", 32'(done), 32'h0);
    req = 2'b11;
    tick();
    chk("t4_post_grant", 32'(grant), 32'h1);
    repeat (5) tick();
    chk("t4_post_done1", 32'(done), 32'h1);
    req = 2'b00;
    tick();

    // Request dropped mid-transaction still completes
    req = 2'b01;
    tick();
    tick();
    req = 2'b00;
    repeat (4) tick();
    chk("t5_c6_done", 32'(done), 32'h1);
    chk("t5_c6_rdata", 32'(rdata), 32'h001);
    tick();
    chk("t5_c7_busy", 32'(busy), 32'h0);
    tick();
    chk("t5_c8_busy", 32'(busy), 32'h0);
    chk("t5_c8_grant", 32'(grant), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_bank_sequencer.md
# gpio_bank_sequencer

Sequences and shares the 12-pin tri-state test bank (GPIO_0 gate-socket pins) between two requesters, e.g. the gate-test engine and a manual probe or self-test engine. Each granted transaction:
- drives a direction/value pattern onto the bank;
- waits a programmable settle time;
- samples all pins through a 2-flop synchronizer and returns the sample with a done pulse;
- returns the bank to high-Z.

The top level owns the tri-state buffers (pin = pins_dir ? pins_out : Z); this block owns the only drivers of pins_dir and pins_out.

## Interface
Parameters:
- PINS, 12, bank width.
- SETTLE, 4, cycles the pattern is held before sampling; legal range 2..255.

Ports:
- clk, in, 1, system clock (slow test clock).
- rst, in, 1, reset, asynchronous, active-high.
- req, in, 2, per-client request level. Held from assertion until that client's done.
- dir0, in, PINS, client 0 direction mask (1 = drive).
- out0, in, PINS, client 0 drive values.
- dir1, in, PINS, client 1 direction mask.
- out1, in, PINS, client 1 drive values.
- grant, out, 2, one-hot; high for the whole transaction of the served client.
- done, out, 2, one-hot, 1-cycle pulse; rdata is valid in that cycle.
- rdata, out, PINS, synchronized pin sample. Held until the next done.
- busy, out, 1, high in any state other than IDLE.
- pins_dir, out, PINS, tri-state enables to the top level.
- pins_out, out, PINS, drive values to the top level.
- pins_in, in, PINS, raw (asynchronous) pin values.

## Operation
- Reset values:
  - grant, done, rdata, pins_dir, pins_out, busy = 0.
  - State = IDLE; settle counter = 0; synchronizer flops = 0.
  - Round-robin pointer last = 1, so client 0 wins first.
- FSM states: IDLE, SETTLE, SAMPLE, RELEASE.
- IDLE:
  - pins_dir = 0 (bank fully high-Z).
  - If no req bit is set, remain in IDLE.
  - If req is nonzero, select the winner w:
    - Only one requester: w = that requester.
    - Both requesting: w = !last.
  - On the selecting edge:
    - grant[w] <= 1.
    - pins_dir <= dirW.
    - pins_out <= outW & dirW (undriven bits are forced to 0).
    - last <= w.
    - counter <= SETTLE-1.
    - Go to SETTLE.
- SETTLE:
  - Pattern is held constant; dir/out inputs are not re-read.
  - Decrement the counter each cycle; when counter == 0, go to SAMPLE.
- SAMPLE:
  - rdata <= sync2 (second synchronizer stage), covering all pins, including driven ones (readback).
  - done[w] <= 1; go to RELEASE.
- RELEASE:
  - done is visible this cycle.
  - On the exit edge: pins_dir <= 0, pins_out <= 0, grant <= 0, done <= 0; go to IDLE.
- Synchronizer: sync1 <= pins_in, sync2 <= sync1 on every clk edge, regardless of state.
- Request rules:
  - If req drops mid-transaction, the transaction still completes and done is still pulsed.
  - A req still high when IDLE re-evaluates starts a new transaction. Clients drop req on the edge after observing done.
- Reset mid-transaction: pins return to high-Z immediately, no done is issued, the pointer resets to last = 1.

## Timing
- Cycle numbering: the selecting edge ends cycle 0 (IDLE with req high).
- Cycle-by-cycle sequence:
  - Cycles 1..SETTLE: SETTLE state; grant and pins_dir are valid from cycle 1.
  - Cycle SETTLE+1: SAMPLE state.
  - Cycle SETTLE+2: done and rdata valid (RELEASE state).
  - Cycle SETTLE+3: IDLE with bank high-Z; a new grant can be selected at the end of this cycle.
- Request-to-done latency: SETTLE+2 cycles. Back-to-back transaction period: SETTLE+3 cycles.
- SETTLE >= 2 guarantees the sample reflects the driven pattern through the 2-flop synchronizer.
- Under continuous contention both clients alternate strictly; neither is starved.
- busy equals (state != IDLE); no combinational paths from inputs to outputs.

## Test plan
- Single request, SETTLE=4:
  - Stimulus: req=01, dir0=0x003, out0=0x001, pins_in looped from the tri-state pins with a pull-down.
  - Required response: grant=01 at cycle 1; pins_dir=0x003, pins_out=0x001 during cycles 1-4; done=01 at cycle 6 with rdata=0x001; pins_dir=0 at cycle 7.
- Simultaneous requests after reset:
  - Stimulus: req=11.
  - Required response: client 0 is served first (done=01); client 1 is served next (grant=10 at cycle 8, done=10 at cycle 13).
- Sustained contention:
  - Stimulus: both req held high for 4 transactions.
  - Required response: grant order 01,10,01,10; period 7 cycles.
- Masking of undriven bits:
  - Stimulus: dir1=0x0F0, out1=0xFFF.
  - Required response: pins_out=0x0F0, pins_dir=0x0F0; an external gate output on bit 8 reads back in rdata[8].
- Reset mid-SETTLE:
  - Stimulus: assert rst at cycle 2.
  - Required response: pins_dir, grant and busy = 0 immediately; no done. After release, req=11 grants client 0 first.
- Request dropped mid-transaction:
  - Stimulus: req0 deasserted at cycle 2.
  - Required response: done=01 still at cycle 6; no second transaction is started.
